// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: op-bit positions,
// FSM state encoding, corner-case flag struct and small helper functions.
package div_issue_ctrl_pkg;

    // Register-bus width; the controller only supports 64-bit operands.
    localparam int REG_W    = 64;
    localparam int DIV_OP_W = 3;

    // Bit positions inside the 3-bit divide op encoding.
    localparam int DIV_OP_UNSIGNED = 0;
    localparam int DIV_OP_REM      = 1;
    localparam int DIV_OP_WORD     = 2;

    localparam logic [63:0] DIV_INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] DIV_INT32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'd0,
        DIV_ST_BUSY  = 2'd1,
        DIV_ST_DRAIN = 2'd2,
        DIV_ST_DONE  = 2'd3
    } div_state_e;

    // Architectural corner cases whose result is fixed by the ISA.
    typedef struct packed {
        logic div_zero;
        logic overflow;
    } div_corner_t;

    // Classify the raw operands; word ops only look at the low 32 bits.
    function automatic div_corner_t div_corner_flags(
        input logic [DIV_OP_W-1:0] op,
        input logic [REG_W-1:0]    rs1,
        input logic [REG_W-1:0]    rs2
    );
        div_corner_t flags;
        if (op[DIV_OP_WORD]) begin
            flags.div_zero = (rs2[31:0] == 32'h0000_0000);
            flags.overflow = ~op[DIV_OP_UNSIGNED]
                           & (rs1[31:0] == DIV_INT32_MIN)
                           & (rs2[31:0] == 32'hFFFF_FFFF);
        end else begin
            flags.div_zero = (rs2 == 64'h0000_0000_0000_0000);
            flags.overflow = ~op[DIV_OP_UNSIGNED]
                           & (rs1 == DIV_INT64_MIN)
                           & (rs2 == 64'hFFFF_FFFF_FFFF_FFFF);
        end
        return flags;
    endfunction

    // Sign-extend a 32-bit word result to the full register width.
    function automatic logic [REG_W-1:0] sext_word(input logic [31:0] value);
        return {{(REG_W-32){value[31]}}, value};
    endfunction

endpackage

// File: rtl/div_result_fmt.sv
// Combinational result formatter: applies the divide-by-zero / overflow
// overrides, selects quotient or remainder and sign-extends word results.
module div_result_fmt import div_issue_ctrl_pkg::*; #(
    parameter int XLEN = REG_W
) (
    input  logic [DIV_OP_W-1:0] op,
    input  div_corner_t         corner,
    input  logic [XLEN-1:0]     rs1,
    input  logic [2*XLEN-1:0]   raw_result,
    output logic [XLEN-1:0]     wb_data
);

    logic [XLEN-1:0] quot_s;
    logic [XLEN-1:0] rem_s;
    logic [XLEN-1:0] sel_s;

    // Overrides come first so word ops sign-extend the overridden value.
    always_comb begin
        quot_s = raw_result[XLEN-1:0];
        rem_s  = raw_result[2*XLEN-1:XLEN];
        case ({corner.div_zero, corner.overflow})
            2'b10, 2'b11: begin
                quot_s = {XLEN{1'b1}};
                rem_s  = rs1;
            end
            2'b01: begin
                quot_s = rs1;
                rem_s  = {XLEN{1'b0}};
            end
            default: begin
                quot_s = raw_result[XLEN-1:0];
                rem_s  = raw_result[2*XLEN-1:XLEN];
            end
        endcase
        sel_s = op[DIV_OP_REM] ? rem_s : quot_s;
        if (op[DIV_OP_WORD]) begin
            wb_data = sext_word(sel_s[31:0]);
        end else begin
            wb_data = sel_s;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the multi-cycle divider: latches the op,
// holds the divider request stable, stalls the pipeline, drains the divider
// on flush and emits a one-cycle formatted writeback pulse.
module div_issue_ctrl import div_issue_ctrl_pkg::*; #(
    parameter int XLEN = REG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [DIV_OP_W-1:0] ex_op,
    input  logic [XLEN-1:0]     ex_rs1,
    input  logic [XLEN-1:0]     ex_rs2,
    input  logic [4:0]          ex_rd,
    input  logic                flush,
    output logic                stall,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                div_valid,
    output logic                div_sign,
    output logic                div_32,
    output logic [XLEN-1:0]     div_rs1,
    output logic [XLEN-1:0]     div_rs2,
    input  logic                div_ready,
    input  logic [2*XLEN-1:0]   div_result
);

    div_state_e          state_r;
    div_state_e          state_s;
    logic                accept_s;
    logic                capture_s;
    logic [DIV_OP_W-1:0] op_r;
    logic [XLEN-1:0]     rs1_r;
    logic [XLEN-1:0]     rs2_r;
    logic [4:0]          rd_r;
    div_corner_t         corner_r;
    logic [2*XLEN-1:0]   result_r;
    logic [XLEN-1:0]     fmt_data_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus the accept/capture strobes for the datapath.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            DIV_ST_IDLE: begin
                if (ex_valid && !flush) begin
                    accept_s = 1'b1;
                    state_s  = DIV_ST_BUSY;
                end else begin
                    state_s  = DIV_ST_IDLE;
                end
            end
            DIV_ST_BUSY: begin
                if (div_ready) begin
                    if (flush) begin
                        state_s   = DIV_ST_IDLE;
                    end else begin
                        capture_s = 1'b1;
                        state_s   = DIV_ST_DONE;
                    end
                end else if (flush) begin
                    // Keep requesting until the divider finishes so its
                    // internal counter returns to zero.
                    state_s = DIV_ST_DRAIN;
                end else begin
                    state_s = DIV_ST_BUSY;
                end
            end
            DIV_ST_DRAIN: begin
                if (div_ready) begin
                    state_s = DIV_ST_IDLE;
                end else begin
                    state_s = DIV_ST_DRAIN;
                end
            end
            DIV_ST_DONE: begin
                state_s = DIV_ST_IDLE;
            end
            default: begin
                state_s = DIV_ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        stall     = 1'b0;
        wb_valid  = 1'b0;
        div_valid = 1'b0;
        case (state_r)
            DIV_ST_IDLE: begin
                stall = ex_valid & ~flush;
            end
            DIV_ST_BUSY: begin
                stall     = 1'b1;
                div_valid = 1'b1;
            end
            DIV_ST_DRAIN: begin
                stall     = ex_valid;
                div_valid = 1'b1;
            end
            DIV_ST_DONE: begin
                // stall stays low so EX retires the op this cycle.
                wb_valid = ~flush;
            end
            default: begin
                stall     = 1'b0;
                wb_valid  = 1'b0;
                div_valid = 1'b0;
            end
        endcase
        div_sign = div_valid & ~op_r[DIV_OP_UNSIGNED];
        div_32   = div_valid & op_r[DIV_OP_WORD];
        div_rs1  = rs1_r;
        div_rs2  = rs2_r;
        wb_rd    = wb_valid ? rd_r : 5'd0;
        wb_data  = wb_valid ? fmt_data_s : {XLEN{1'b0}};
    end

    // Operand latch at issue and result capture on the divider handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= {DIV_OP_W{1'b0}};
            rs1_r    <= {XLEN{1'b0}};
            rs2_r    <= {XLEN{1'b0}};
            rd_r     <= 5'd0;
            corner_r <= '{div_zero: 1'b0, overflow: 1'b0};
            result_r <= {(2*XLEN){1'b0}};
        end else begin
            if (accept_s) begin
                op_r     <= ex_op;
                rs1_r    <= ex_rs1;
                rs2_r    <= ex_rs2;
                rd_r     <= ex_rd;
                corner_r <= div_corner_flags(ex_op, ex_rs1, ex_rs2);
            end
            if (capture_s) begin
                result_r <= div_result;
            end
        end
    end

    div_result_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .op         (op_r),
        .corner     (corner_r),
        .rs1        (rs1_r),
        .raw_result (result_r),
        .wb_data    (fmt_data_s)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divider model,
// directed corner cases, flush/drain, reset and randomized ops.
module tb_div_issue_ctrl;

    logic         clk;
    logic         rst;
    logic         ex_valid;
    logic [2:0]   ex_op;
    logic [63:0]  ex_rs1;
    logic [63:0]  ex_rs2;
    logic [4:0]   ex_rd;
    logic         flush;
    logic         stall;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [63:0]  wb_data;
    logic         div_valid;
    logic         div_sign;
    logic         div_32;
    logic [63:0]  div_rs1;
    logic [63:0]  div_rs2;
    logic         div_ready;
    logic [127:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;

    div_issue_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .div_valid  (div_valid),
        .div_sign   (div_sign),
        .div_32     (div_32),
        .div_rs1    (div_rs1),
        .div_rs2    (div_rs2),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (ISA-level) ----------------
    function automatic bit is_corner(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2])
            return (b[31:0] == 32'd0) ||
                   (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // {rem, quot} per RISC-V rules; word results already sign-extended.
    function automatic logic [127:0] arch_qr(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        logic [31:0] q32, r32;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
        if (op[2]) begin
            if (b[31:0] == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a[31:0];
            end else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = 32'd0;
            end else if (op[0]) begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end else begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = 64'hFFFF_FFFF_FFFF_FFFF; r = a;
            end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a; r = 64'd0;
            end else if (op[0]) begin
                q = a / b; r = a % b;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] qr;
        qr = arch_qr(op, a, b);
        return op[1] ? qr[127:64] : qr[63:0];
    endfunction

    // ---------------- behavioural divider ----------------
    // Ready on the 67th consecutive valid cycle, or at once for zero/overflow
    // (with garbage data, so the controller must supply the override).
    logic [6:0]   dcnt;
    logic [127:0] junk;
    logic [2:0]   dop;
    logic [127:0] dqr;
    assign dop = {div_32, 1'b0, ~div_sign};

    always_ff @(posedge clk) begin
        junk <= {$urandom, $urandom, $urandom, $urandom};
        if (rst) dcnt <= 7'd0;
        else if (div_valid && div_ready) dcnt <= 7'd0;
        else if (div_valid) dcnt <= dcnt + 7'd1;
    end

    always_comb begin
        div_ready  = 1'b0;
        div_result = junk;
        dqr        = arch_qr(dop, div_rs1, div_rs2);
        if (div_valid) begin
            if (is_corner(dop, div_rs1, div_rs2)) begin
                div_ready = 1'b1;
            end else begin
                div_ready  = (dcnt == 7'd66);
                div_result = dqr;
                if (dop[2]) begin
                    div_result[127:96] = junk[127:96];
                    div_result[63:32]  = junk[63:32];
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op in EX at posedge+2 and hold it until the pipeline retires it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input int exp_lat);
        int wb_k = -1;
        int stall_n = 0;
        bit done = 1'b0;
        logic [63:0] got_data = 64'd0;
        logic [4:0]  got_rd = 5'd0;
        logic dv0 = 1'b1;
        logic dv1 = 1'b0;
        ex_valid = 1'b1; ex_op = op; ex_rs1 = a; ex_rs2 = b; ex_rd = rd; flush = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (k == 0) dv0 = div_valid;
            if (k == 1) dv1 = div_valid;
            if (stall) stall_n++;
            if (wb_valid && wb_k < 0) begin
                wb_k = k; got_data = wb_data; got_rd = wb_rd;
            end
            if (!stall) done = 1'b1;
            @(posedge clk); #2;
        end
        ex_valid = 1'b0;
        check_value({tag, "_retired"},   64'(done), 64'd1);
        check_value({tag, "_wb_cycle"},  64'(wb_k), 64'(exp_lat));
        check_value({tag, "_stall_len"}, 64'(stall_n), 64'(exp_lat));
        check_value({tag, "_data"},      got_data, exp);
        check_value({tag, "_rd"},        64'(got_rd), 64'(rd));
        check_value({tag, "_div_valid_start"}, {62'd0, dv0, dv1}, 64'd1);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(0, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [2:0]  r_op;
    logic [63:0] r_a, r_b;
    int          wb_seen, bad_dv;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_op = 3'd0; ex_rs1 = 64'd0; ex_rs2 = 64'd0;
        ex_rd = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_stall",     64'(stall), 64'd0);
        check_value("rst_wb_valid",  64'(wb_valid), 64'd0);
        check_value("rst_wb_data",   wb_data, 64'd0);
        check_value("rst_wb_rd",     64'(wb_rd), 64'd0);
        check_value("rst_div_ctl",   {61'd0, div_valid, div_sign, div_32}, 64'd0);
        check_value("rst_div_rs1",   div_rs1, 64'd0);
        check_value("rst_div_rs2",   div_rs2, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Directed ISA cases.
        run_op("divu_100_7", 3'b001, 64'd100, 64'd7, 5'd5, 64'd14, 68);
        run_op("rem_m7_2",   3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 68);
        run_op("remu_m7_2",  3'b011, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'd1, 68);
        run_op("div_ovf",    3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
               64'h8000_0000_0000_0000, 2);
        run_op("rem_ovf",    3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0, 2);
        run_op("divw_ovf",   3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10,
               64'hFFFF_FFFF_8000_0000, 2);
        run_op("divu_zero",  3'b001, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_op("remw_zero",  3'b110, 64'h0000_0001_8000_0001, 64'd0, 5'd12, 64'hFFFF_FFFF_8000_0001, 2);

        // Flush at T+10 while a second DIV waits in EX.
        ex_valid = 1'b1; ex_op = 3'b000; ex_rs1 = 64'd1000; ex_rs2 = 64'd7; ex_rd = 5'd3;
        wb_seen = 0; bad_dv = 0;
        for (int k = 0; k < 68; k++) begin
            if (k == 10) begin
                flush = 1'b1;
            end else if (k == 11) begin
                flush = 1'b0; ex_op = 3'b000; ex_rs1 = 64'hFFFF_FFFF_FFFF_FF9C; ex_rs2 = 64'd9; ex_rd = 5'd4;
            end
            @(negedge clk);
            if (wb_valid) wb_seen++;
            if (k >= 1 && (!div_valid || div_rs1 != 64'd1000 || div_rs2 != 64'd7)) bad_dv++;
            @(posedge clk); #2;
        end
        check_value("flush_no_wb",    64'(wb_seen), 64'd0);
        check_value("drain_hold",     64'(bad_dv), 64'd0);
        run_op("flush_op2", 3'b000, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9, 5'd4,
               ref_result(3'b000, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9), 68);

        // Reset in the middle of a divide.
        ex_valid = 1'b1; ex_op = 3'b001; ex_rs1 = 64'd12345; ex_rs2 = 64'd17; ex_rd = 5'd9;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); @(posedge clk); #2;
        end
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_value("mid_rst_outputs", {61'd0, stall, div_valid, wb_valid}, 64'd0);
        @(posedge clk); #2;
        run_op("divu_9_3", 3'b001, 64'd9, 64'd3, 5'd13, 64'd3, 68);

        // Randomized ops against the ISA reference.
        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            run_op("rnd", r_op, r_a, r_b, 5'($urandom_range(1, 31)),
                   ref_result(r_op, r_a, r_b), is_corner(r_op, r_a, r_b) ? 2 : 68);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_value("idle_stall", 64'(stall), 64'd0);
                @(posedge clk); #2;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
